// File: rtl/digiota_trim_cal.sv
// digiota_trim_cal: SAR offset calibration for the digital OTA with
// per-bit majority voting over a synchronized comparator output.
// Ports: clk, rst (async, active-high), start, abort, manual_en,
//   manual_trim[TRIM_W] in; cmp_in (async) in; trim_out[TRIM_W],
//   cal_en, busy, done (1-cycle pulse) out.
module digiota_trim_cal #(
  parameter int TRIM_W        = 6,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLES       = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              manual_en,
  input  logic [TRIM_W-1:0] manual_trim,
  input  logic              cmp_in,
  output logic [TRIM_W-1:0] trim_out,
  output logic              cal_en,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ?
                           SETTLE_CYCLES : SAMPLES;
  localparam int CNT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int ONES_W = $clog2(SAMPLES + 1);
  localparam int IDX_W  = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  localparam logic [TRIM_W-1:0] MID =
    {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAM_LAST =
    CNT_W'(SAMPLES - 1);
  localparam logic [ONES_W-1:0] HALF =
    ONES_W'(SAMPLES / 2);
  localparam logic [IDX_W-1:0] MSB_IDX =
    IDX_W'(TRIM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_nxt;
  logic [TRIM_W-1:0] trial_q, trial_d;
  logic [TRIM_W-1:0] result_q, result_d;
  logic [TRIM_W-1:0] dec_trial;

  // Two-flop synchronizer; only sync_q[1] is ever used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], cmp_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ones_q   <= '0;
      idx_q    <= '0;
      trial_q  <= MID;
      result_q <= MID;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      idx_q    <= idx_d;
      trial_q  <= trial_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    idx_d     = idx_q;
    trial_d   = trial_q;
    result_d  = result_q;
    idx_nxt   = idx_q - IDX_W'(1);
    dec_trial = trial_q;
    // Majority says "too high": drop the bit under test.
    if (ones_q > HALF) begin
      dec_trial[idx_q] = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start && !manual_en && !abort) begin
          state_d = S_SETTLE;
          idx_d   = MSB_IDX;
          trial_d = MID;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == SET_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          ones_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          ones_d = ones_q + ONES_W'(sync_q[1]);
          if (cnt_q == SAM_LAST) begin
            state_d = S_DECIDE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DECIDE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          dec_trial[idx_nxt] = 1'b1;
          trial_d = dec_trial;
          idx_d   = idx_nxt;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          trial_d  = dec_trial;
          result_d = dec_trial;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy   = (state_q == S_SETTLE) ||
             (state_q == S_SAMPLE) ||
             (state_q == S_DECIDE);
    cal_en = busy;
    done   = (state_q == S_DONE);
    if (busy) begin
      trim_out = trial_q;
    end else if (state_q == S_IDLE && manual_en) begin
      trim_out = manual_trim;
    end else begin
      trim_out = result_q;
    end
  end

endmodule

// File: tb/tb_digiota_trim_cal.sv
// Bench for digiota_trim_cal: random SAR runs against a
// plain-arithmetic model, scoreboard monitor on done/trim.
module tb_digiota_trim_cal;

  localparam int TW  = 6;
  localparam int SC  = 16;
  localparam int NS  = 15;
  localparam int LAT = 1 + TW * (SC + NS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          manual_en;
  logic [TW-1:0] manual_trim;
  logic          cmp_in;
  logic [TW-1:0] trim_out;
  logic          cal_en;
  logic          busy;
  logic          done;

  digiota_trim_cal #(
    .TRIM_W(TW),
    .SETTLE_CYCLES(SC),
    .SAMPLES(NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .manual_en(manual_en),
    .manual_trim(manual_trim),
    .cmp_in(cmp_in),
    .trim_out(trim_out),
    .cal_en(cal_en),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int start_abs = 0;
  int mode = 0;
  int thr = 63;
  logic [NS-1:0] pat = '0;
  int t1 = 32;
  int t2 = 32;
  int done_cnt = 0;
  int last_trim = -1;
  bit trk = 1'b0;
  int exp_res_q[$];
  int exp_lat_q[$];
  int exp_trim_q[$];

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Comparator model: mode 0 is (trim > thr) delayed two
  // cycles; mode 1 plays a fixed pattern into the MSB votes.
  always @(negedge clk) begin : drv
    int rel;
    rel = edge_n + 1 - start_abs;
    if (mode == 1) begin
      if (rel >= 15 && rel <= 29) cmp_in = pat[rel-15];
      else cmp_in = 1'b0;
    end else begin
      cmp_in = (t2 > thr);
    end
    t2 = t1;
    t1 = int'(trim_out);
  end

  always @(negedge clk) begin : mon
    int r;
    int l;
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (exp_res_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          r = exp_res_q.pop_front();
          l = exp_lat_q.pop_front();
          chk("final_trim", int'(trim_out), r);
          chk("done_latency", edge_n + 1 - start_abs, l);
        end
      end
      if (busy && trk) begin
        if (int'(trim_out) != last_trim) begin
          if (exp_trim_q.size() == 0)
            chk("extra_trial", int'(trim_out), -1);
          else
            chk("trial_step", int'(trim_out),
                exp_trim_q.pop_front());
          last_trim = int'(trim_out);
        end
      end else if (!busy) begin
        last_trim = -1;
      end
    end
  end

  // SAR from first principles: try each bit, keep it unless
  // the comparator majority reports "too high".
  task automatic model_push(input int m, input int th,
                            input int k);
    int prefix;
    int c;
    bit hi;
    prefix = 0;
    for (int b = TW - 1; b >= 0; b--) begin
      c = prefix | (1 << b);
      exp_trim_q.push_back(c);
      if (m == 0) hi = (c > th);
      else hi = (b == TW - 1) && (k > NS / 2);
      if (!hi) prefix = c;
    end
    exp_res_q.push_back(prefix);
    exp_lat_q.push_back(LAT);
  endtask

  task automatic make_pat(input int k);
    int n;
    pat = '0;
    n = 0;
    while (n < k) begin
      int p;
      p = $urandom_range(NS - 1, 0);
      if (!pat[p]) begin
        pat[p] = 1'b1;
        n++;
      end
    end
  endtask

  task automatic run_cal(input int m, input int th,
                         input int k, input bit poke);
    int bad;
    int rel;
    bit eb;
    bad = 0;
    mode = m;
    thr = th;
    if (m == 1) make_pat(k);
    model_push(m, th, k);
    @(negedge clk);
    start = 1'b1;
    start_abs = edge_n + 1;
    trk = 1'b1;
    for (int c = 0; c < 260 && exp_res_q.size() != 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      rel = edge_n + 1 - start_abs;
      eb = (rel >= 1 && rel <= LAT - 1);
      if (busy !== eb || cal_en !== eb) bad++;
      if (poke) begin
        if (rel == 60) start = 1'b1;
        if (rel == 70) manual_en = 1'b1;
        if (rel == 150) manual_en = 1'b0;
      end
    end
    manual_en = 1'b0;
    if (exp_res_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_res_q.delete();
      exp_lat_q.delete();
    end
    chk("busy_window", bad, 0);
    chk("trials_left", exp_trim_q.size(), 0);
    exp_trim_q.delete();
    trk = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_abort(input int prev);
    int d0;
    mode = 0;
    thr = 37;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    start_abs = edge_n + 1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (edge_n + 1 - start_abs == 100) begin
        chk("pre_abort_busy", busy, 1);
        abort = 1'b1;
        break;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cal_en", cal_en, 0);
    chk("abort_trim", int'(trim_out), prev);
    repeat (200) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    manual_en = 1'b0;
    manual_trim = 6'd5;
    cmp_in = 1'b0;
    #12;
    chk("rst_trim", int'(trim_out), 32);
    chk("rst_busy", busy, 0);
    chk("rst_cal_en", cal_en, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_abort(32);
    run_cal(0, 37, 0, 1'b1);
    run_cal(0, 0, 0, 1'b0);
    run_cal(0, 63, 0, 1'b0);
    run_cal(1, 0, 7, 1'b0);
    run_cal(1, 0, 8, 1'b0);
    run_cal(0, 37, 0, 1'b0);
    run_abort(37);

    abort = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_beats_start", busy, 0);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);

    manual_en = 1'b1;
    @(negedge clk);
    chk("manual_trim", int'(trim_out), 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("manual_start_ignored", busy, 0);
    chk("manual_trim_hold", int'(trim_out), 5);
    manual_en = 1'b0;
    @(negedge clk);
    chk("manual_off_result", int'(trim_out), 37);

    repeat (4) run_cal(0, $urandom_range(70, 0), 0, 1'b0);
    run_cal(0, 10, 0, 1'b0);

    mode = 0;
    thr = 20;
    @(negedge clk);
    start = 1'b1;
    start_abs = edge_n + 1;
    @(negedge clk);
    start = 1'b0;
    while (edge_n + 1 - start_abs < 50) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_trim", int'(trim_out), 32);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cal_en", cal_en, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_result", int'(trim_out), 32);
    run_cal(0, 45, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
